// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and widths used by the shifter units.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned SHIFT_AMT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shr_state_t;

    typedef enum logic {
        SHIFT_LOGICAL,
        SHIFT_ARITH
    } shift_kind_t;

endpackage

// File: rtl/shr_step.sv
// Combinational right shift by 0..STEP bits, vacated bits taken from fill.
module shr_step #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 4,
    parameter int unsigned AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH+STEP-1:0] extended;

    always_comb begin
        extended = {{STEP{fill}}, data_in};
        data_out = WIDTH'(extended >> amount);
    end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle logical/arithmetic right shifter: accepts a request, shifts
// up to STEP bits per cycle, and holds the result until the consumer takes it.
module shift_right_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [SHIFT_AMT_WIDTH-1:0] shift_amount,
    input  logic                       arith,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           shifted_data,
    output logic                       busy
);

    localparam int unsigned REM_W = $clog2(WIDTH + 1);
    localparam int unsigned AMT_W = $clog2(STEP + 1);

    shr_state_t        state_q,     state_d;
    shift_kind_t       kind_q,      kind_d;
    logic [WIDTH-1:0]  data_q,      data_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;

    logic [REM_W-1:0]  clamped_amt;
    logic [AMT_W-1:0]  step_amt;
    logic              step_fill;
    logic [WIDTH-1:0]  step_out;

    shr_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .data_in  (data_q),
        .amount   (step_amt),
        .fill     (step_fill),
        .data_out (step_out)
    );

    always_comb begin
        clamped_amt = (shift_amount >= SHIFT_AMT_WIDTH'(WIDTH)) ? REM_W'(WIDTH)
                                                                : REM_W'(shift_amount);
        // Never step past what is left, so odd counts finish exactly.
        step_amt  = (remaining_q > REM_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(remaining_q);
        step_fill = (kind_q == SHIFT_ARITH) && data_q[WIDTH-1];

        state_d     = state_q;
        kind_d      = kind_q;
        data_d      = data_q;
        remaining_d = remaining_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d      = data_in;
                    kind_d      = arith ? SHIFT_ARITH : SHIFT_LOGICAL;
                    remaining_d = clamped_amt;
                    state_d     = (clamped_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d      = step_out;
                remaining_d = remaining_q - REM_W'(step_amt);
                if (remaining_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= SHIFT_LOGICAL;
            data_q      <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign shifted_data = data_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Scoreboard bench for shift_right_unit: directed cases plus randomized
// requests with random backpressure, checked against an arithmetic reference.
module tb_shift_right_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_in = '0;
    logic [15:0] shift_amount = '0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] shifted_data;
    logic        busy;

    shift_right_unit #(.WIDTH(16), .STEP(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .arith        (arith),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .shifted_data (shifted_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          latency;
        int          accept_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   seen_valid = 0;
    int   bp_mode = 0;   // 0: ready high, 1: random, 2: held low

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(logic [15:0] d, logic [15:0] amt, logic a);
        exp_t e;
        int   eff;
        eff = (amt > 16) ? 16 : int'(amt);
        if (a) e.data = 16'($signed(d) >>> eff);
        else   e.data = (eff >= 16) ? 16'h0 : (d >> eff);
        e.latency = 1 + (eff + 3) / 4;
        e.accept_cyc = 0;
        return e;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples just before the following rising edge.
    always @(negedge clk) begin
        cyc++;
        #2;
        if (rst_n) begin
            if (in_ready && out_valid) chk("ready_valid_exclusive", 1, 0);
            if (busy !== !in_ready)    chk("busy_vs_in_ready", {31'b0, busy}, {31'b0, !in_ready});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - sb[0].accept_cyc, sb[0].latency);
                        seen_valid = 1;
                    end
                    chk("shifted_data", {16'b0, shifted_data}, {16'b0, sb[0].data});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen_valid = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [15:0] amt, input logic a);
        exp_t e;
        int   waited = 0;
        @(negedge clk); #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        e = model(d, amt, a);
        e.accept_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b1; data_in = d; shift_amount = amt; arith = a;
        @(negedge clk); #1;
        in_valid = 1'b0;
        data_in = 16'($urandom); shift_amount = 16'($urandom); arith = 1'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || busy) && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (sb.size() != 0 || busy) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        // Reset values
        #12;
        chk("reset_in_ready",  {31'b0, in_ready},  1);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_busy",      {31'b0, busy},      0);
        chk("reset_data",      {16'b0, shifted_data}, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        send(16'h8000, 16'd1,     1'b0);
        send(16'h8000, 16'd15,    1'b0);
        send(16'h8000, 16'd12,    1'b1);
        send(16'h1234, 16'd0,     1'b0);
        send(16'h8001, 16'h0100,  1'b0);
        send(16'h8001, 16'h0100,  1'b1);
        send(16'h7FFF, 16'd16,    1'b1);
        send(16'hFFFF, 16'hFFFF,  1'b1);
        drain();

        // Backpressure with an ignored second request
        bp_mode = 2;
        send(16'h00F0, 16'd4, 1'b0);
        begin
            int w = 0;
            while (!out_valid && w < 20) begin @(negedge clk); #1; w++; end
        end
        chk("bp_valid_reached", {31'b0, out_valid}, 1);
        in_valid = 1'b1; data_in = 16'hAAAA; shift_amount = 16'd2; arith = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("bp_out_valid_held", {31'b0, out_valid}, 1);
            chk("bp_in_ready_low",   {31'b0, in_ready},  0);
            chk("bp_data_held",      {16'b0, shifted_data}, 16'h000F);
        end
        bp_mode = 0;
        @(negedge clk); #1;
        in_valid = 1'b0;
        begin
            int w = 0;
            while (out_valid && w < 5) begin @(negedge clk); #1; w++; end
        end
        chk("bp_release_in_ready", {31'b0, in_ready}, 1);
        chk("bp_release_busy",     {31'b0, busy},     0);
        chk("bp_queue_empty",      sb.size(),         0);

        // Reset in the middle of a shift
        send(16'hF000, 16'd16, 1'b1);
        chk("mid_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        sb.delete();
        seen_valid = 0;
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},  1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy",      {31'b0, busy},      0);
        chk("rst_data",      {16'b0, shifted_data}, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        send(16'hF000, 16'd16, 1'b1);
        send(16'h0F0F, 16'd7,  1'b0);
        drain();

        // Randomized requests under random backpressure
        bp_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] amt;
            amt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            send(16'($urandom), amt, 1'($urandom));
        end
        drain();
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
